// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes,
// ALUOp/PCSrc/RegDst constants and the instruction-class record.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_WB   = 3'b011,
        S_MEM  = 3'b100,
        S_HALT = 3'b101,
        S_TRAP = 3'b110
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Row order of OP_TABLE; the decoder indexes its match vector with these.
    localparam int I_ADD = 0, I_SUB = 1, I_ADDI = 2, I_OR = 3, I_AND = 4, I_ORI = 5,
                   I_SLL = 6, I_SLT = 7, I_SLTIU = 8, I_SW = 9, I_LW = 10, I_BEQ = 11,
                   I_BLTZ = 12, I_J = 13, I_JR = 14, I_JAL = 15, I_HALT = 16;
    localparam int N_OPS = 17;

    localparam logic [5:0] OP_TABLE [N_OPS] = '{
        OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT, OP_SLTIU,
        OP_SW, OP_LW, OP_BEQ, OP_BLTZ, OP_J, OP_JR, OP_JAL, OP_HALT
    };

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_NOP  = 3'b111;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [1:0] REGDST_R31 = 2'b00;
    localparam logic [1:0] REGDST_RT  = 2'b01;
    localparam logic [1:0] REGDST_RD  = 2'b10;

    typedef struct packed {
        logic alu;
        logic lw;
        logic sw;
        logic beq;
        logic bltz;
        logic j;
        logic jr;
        logic jal;
        logic halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_decode.sv
// Static opcode decode: one-hot instruction class plus the datapath selects
// that depend only on the opcode.
module mc_op_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output op_class_t       cls,
    output logic [2:0]      alu_op,
    output logic            alu_src_a,
    output logic            alu_src_b,
    output logic            ext_sel,
    output logic [1:0]      reg_dst,
    output logic            db_data_src,
    output logic            wr_reg_d_src
);

    logic [N_OPS-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_OPS; gi++) begin : g_match
            assign hit[gi] = (op == OP_W'(OP_TABLE[gi]));
        end
    endgenerate

    always_comb begin
        cls         = '0;
        cls.alu     = hit[I_ADD] | hit[I_SUB] | hit[I_ADDI] | hit[I_OR] | hit[I_AND]
                    | hit[I_ORI] | hit[I_SLL] | hit[I_SLT] | hit[I_SLTIU];
        cls.lw      = hit[I_LW];
        cls.sw      = hit[I_SW];
        cls.beq     = hit[I_BEQ];
        cls.bltz    = hit[I_BLTZ];
        cls.j       = hit[I_J];
        cls.jr      = hit[I_JR];
        cls.jal     = hit[I_JAL];
        cls.halt    = hit[I_HALT];
        cls.illegal = ~|hit;

        alu_op = ALU_NOP;
        if (hit[I_ADD] | hit[I_ADDI] | hit[I_LW] | hit[I_SW])     alu_op = ALU_ADD;
        else if (hit[I_SUB] | hit[I_BEQ] | hit[I_BLTZ])           alu_op = ALU_SUB;
        else if (hit[I_SLTIU])                                    alu_op = ALU_SLTU;
        else if (hit[I_SLT])                                      alu_op = ALU_SLT;
        else if (hit[I_SLL])                                      alu_op = ALU_SLL;
        else if (hit[I_OR] | hit[I_ORI])                          alu_op = ALU_OR;
        else if (hit[I_AND])                                      alu_op = ALU_AND;

        // rd for register-register ops, rt for immediates and loads, r31 for jal
        reg_dst = REGDST_R31;
        if (hit[I_ADD] | hit[I_SUB] | hit[I_OR] | hit[I_AND] | hit[I_SLL] | hit[I_SLT])
            reg_dst = REGDST_RD;
        else if (hit[I_ADDI] | hit[I_ORI] | hit[I_SLTIU] | hit[I_LW])
            reg_dst = REGDST_RT;
    end

    assign alu_src_a    = hit[I_SLL];
    assign alu_src_b    = hit[I_ADDI] | hit[I_ORI] | hit[I_SLTIU] | hit[I_LW] | hit[I_SW];
    assign ext_sel      = ~(hit[I_ORI] | hit[I_SLTIU]);
    assign db_data_src  = hit[I_LW];
    assign wr_reg_d_src = ~hit[I_JAL];

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control FSM (IF/ID/EXE/MEM/WB plus HALT/TRAP) with memory wait timeout.
// Build option MCCTRL_ILLEGAL_TRAP_EN: illegal opcodes and timeouts go to TRAP and add illegal_op.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W         = 6,
    parameter int ALUOP_W      = 3,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               sign,
    input  logic               mem_ready,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               mRD,
    output logic               mWR,
    output logic               InsMemRW,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               DBDataSrc,
    output logic               WrRegDSrc,
    output logic               ExtSel,
    output logic [1:0]         RegDst,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic               halted
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    localparam state_t TIMEOUT_STATE = S_TRAP;
`else
    localparam state_t TIMEOUT_STATE = S_HALT;
`endif

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_next;
    op_class_t         cls;
    logic [2:0]        alu_op_dec;
    logic              timeout, branch_taken;

    mc_op_decode #(.OP_W(OP_W)) u_decode (
        .op           (op),
        .cls          (cls),
        .alu_op       (alu_op_dec),
        .alu_src_a    (ALUSrcA),
        .alu_src_b    (ALUSrcB),
        .ext_sel      (ExtSel),
        .reg_dst      (RegDst),
        .db_data_src  (DBDataSrc),
        .wr_reg_d_src (WrRegDSrc)
    );

    assign ALUOp        = ALUOP_W'(alu_op_dec);
    assign branch_taken = (cls.beq & zero) | (cls.bltz & sign & ~zero);
    // This low cycle is the MEM_WAIT_MAX-th in a row.
    assign timeout      = (MEM_WAIT_MAX != 0) && !mem_ready && (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IF;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = '0;
        PCWre      = 1'b0;
        IRWre      = 1'b0;
        RegWre     = 1'b0;
        mRD        = 1'b0;
        mWR        = 1'b0;
        InsMemRW   = 1'b0;
        case (state_reg)
            S_IF: begin
                InsMemRW = 1'b1;
                if (mem_ready) begin
                    IRWre      = 1'b1;
                    state_next = S_ID;
                end else if (timeout) begin
                    state_next = TIMEOUT_STATE;
                end else begin
                    wait_next = wait_cnt_reg + 1'b1;
                end
            end
            S_ID: begin
                if (cls.j | cls.jr) begin
                    PCWre      = 1'b1;
                    state_next = S_IF;
                end else if (cls.jal) begin
                    PCWre      = 1'b1;
                    RegWre     = 1'b1;
                    state_next = S_IF;
                end else if (cls.halt) begin
                    state_next = S_HALT;
                end else if (cls.alu | cls.beq | cls.bltz | cls.lw | cls.sw) begin
                    state_next = S_EXE;
                end else if (cls.illegal) begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                    state_next = S_TRAP;
`else
                    PCWre      = 1'b1;
                    state_next = S_IF;
`endif
                end
            end
            S_EXE: begin
                if (cls.beq | cls.bltz) begin
                    PCWre      = 1'b1;
                    state_next = S_IF;
                end else if (cls.lw | cls.sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                mRD = cls.lw;
                mWR = cls.sw;
                if (mem_ready) begin
                    if (cls.lw) begin
                        state_next = S_WB;
                    end else begin
                        PCWre      = 1'b1;
                        state_next = S_IF;
                    end
                end else if (timeout) begin
                    state_next = TIMEOUT_STATE;
                end else begin
                    wait_next = wait_cnt_reg + 1'b1;
                end
            end
            S_WB: begin
                RegWre     = 1'b1;
                PCWre      = 1'b1;
                state_next = S_IF;
            end
            S_HALT, S_TRAP: begin
                state_next = state_reg;
            end
            default: begin
                state_next = S_IF;
            end
        endcase
        // A reset cycle aborts the instruction: no enable may fire while rst_n is low.
        if (!rst_n) begin
            PCWre    = 1'b0;
            IRWre    = 1'b0;
            RegWre   = 1'b0;
            mRD      = 1'b0;
            mWR      = 1'b0;
            InsMemRW = 1'b0;
        end
    end

    always_comb begin
        PCSrc = PCSRC_SEQ;
        if (cls.jr)                PCSrc = PCSRC_JR;
        else if (cls.j | cls.jal)  PCSrc = PCSRC_J;
        else if (branch_taken)     PCSrc = PCSRC_BR;
    end

    assign state  = state_reg;
    assign halted = (state_reg == S_HALT);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign illegal_op = (state_reg == S_TRAP);
`endif

endmodule
